// File: rtl/regbank_initiator.sv
// Register-bank initiator: sequences a write and/or two-operand read onto a synchronous bank.
// Optional REGBANK_X0_ZERO_EN: register 0 is hardwired zero (its writes skipped, its reads forced 0).
module regbank_initiator #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SEL_W  = 5
) (
   input  logic              clk,
   input  logic              rstBar,
   input  logic              rdReq,
   input  logic [SEL_W-1:0]  rdSel0,
   input  logic [SEL_W-1:0]  rdSel1,
   input  logic              wrReq,
   input  logic [SEL_W-1:0]  wrSel,
   input  logic [DATA_W-1:0] wrData,
   output logic              reqReady,
   output logic              rdValid,
   output logic [DATA_W-1:0] rdData0,
   output logic [DATA_W-1:0] rdData1,
   output logic              bankCSBar,
   output logic              bankRDWRBar,
   output logic [SEL_W-1:0]  bankSelSrc0,
   output logic [SEL_W-1:0]  bankSelSrc1,
   output logic [SEL_W-1:0]  bankSelDst,
   output logic [DATA_W-1:0] bankDst,
   input  logic [DATA_W-1:0] bankSrc0,
   input  logic [DATA_W-1:0] bankSrc1
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

   state_t state, nxt;
   logic   rdPend;
   logic   accept;
   logic   skipWr;
   logic   csBarD;
   logic   rdwrBarD;

   assign accept = (state == IDLE) && (rdReq || wrReq);

   always_comb begin
`ifdef REGBANK_X0_ZERO_EN
      skipWr = (wrSel == '0);
`else
      skipWr = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rstBar) begin
      if (!rstBar) state <= IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (wrReq && !skipWr) nxt = WRITE;
               else if (rdReq)       nxt = READ;
            end
         end
         WRITE:   nxt = rdPend ? READ : IDLE;
         READ:    nxt = CAPTURE;
         CAPTURE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Bank strobes are decoded from the next state so they leave a flop aligned with the state.
   always_comb begin
      reqReady = (state == IDLE);
      csBarD   = (nxt == IDLE);
      rdwrBarD = (nxt != WRITE);
   end

   always_ff @(posedge clk or negedge rstBar) begin
      if (!rstBar) begin
         bankCSBar   <= 1'b1;
         bankRDWRBar <= 1'b1;
         bankSelSrc0 <= '0;
         bankSelSrc1 <= '0;
         bankSelDst  <= '0;
         bankDst     <= '0;
         rdPend      <= 1'b0;
         rdValid     <= 1'b0;
         rdData0     <= '0;
         rdData1     <= '0;
      end else begin
         bankCSBar   <= csBarD;
         bankRDWRBar <= rdwrBarD;
         rdValid     <= (state == CAPTURE);
         // The bank-side select/data registers double as the request latches.
         if (accept) begin
            rdPend <= rdReq;
            if (wrReq) begin
               bankSelDst <= wrSel;
               bankDst    <= wrData;
            end
            if (rdReq) begin
               bankSelSrc0 <= rdSel0;
               bankSelSrc1 <= rdSel1;
            end
         end
         if (state == CAPTURE) begin
`ifdef REGBANK_X0_ZERO_EN
            rdData0 <= (bankSelSrc0 == '0) ? '0 : bankSrc0;
            rdData1 <= (bankSelSrc1 == '0) ? '0 : bankSrc1;
`else
            rdData0 <= bankSrc0;
            rdData1 <= bankSrc1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_regbank_initiator.sv
// Directed bench for regbank_initiator with a behavioural 32-entry bank attached.
module tb_regbank_initiator;

   logic        clk;
   logic        rstBar;
   logic        rdReq, wrReq;
   logic [4:0]  rdSel0, rdSel1, wrSel;
   logic [31:0] wrData;
   logic        reqReady, rdValid;
   logic [31:0] rdData0, rdData1;
   logic        bankCSBar, bankRDWRBar;
   logic [4:0]  bankSelSrc0, bankSelSrc1, bankSelDst;
   logic [31:0] bankDst, bankSrc0, bankSrc1;

   int tests = 0;
   int fails = 0;
   logic [31:0] lastD0 = '0;
   logic [31:0] lastD1 = '0;

   regbank_initiator #(.DATA_W(32), .SEL_W(5)) dut (
      .clk(clk), .rstBar(rstBar),
      .rdReq(rdReq), .rdSel0(rdSel0), .rdSel1(rdSel1),
      .wrReq(wrReq), .wrSel(wrSel), .wrData(wrData),
      .reqReady(reqReady), .rdValid(rdValid),
      .rdData0(rdData0), .rdData1(rdData1),
      .bankCSBar(bankCSBar), .bankRDWRBar(bankRDWRBar),
      .bankSelSrc0(bankSelSrc0), .bankSelSrc1(bankSelSrc1), .bankSelDst(bankSelDst),
      .bankDst(bankDst), .bankSrc0(bankSrc0), .bankSrc1(bankSrc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank: writes and reads on the edge ending a selected cycle; contents reload on reset.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (!rstBar) begin
         for (int unsigned i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 | i;
         mem[5] <= 32'h11;
         mem[6] <= 32'h22;
      end else if (!bankCSBar) begin
         if (!bankRDWRBar) mem[bankSelDst] <= bankDst;
         else begin
            bankSrc0 <= mem[bankSelSrc0];
            bankSrc1 <= mem[bankSelSrc1];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [4:0]  s0;
      logic [4:0]  s1;
      logic [4:0]  ws;
      logic [31:0] wd;
      int          rdyCyc;
      int          wrCyc;
      int          vldCyc;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vecs [9];

   // Starts and ends on a falling edge with the DUT idle.
   task automatic run_vec(input vec_t v);
      int rdy = 0, vld = 0, vcnt = 0, wcnt = 0, rcnt = 0;
      logic [31:0] d0 = '0, d1 = '0, ddat = '0;
      logic [4:0]  dsel = '0, rs0 = '0, rs1 = '0;
      chk("ready_before", 32'(reqReady), 32'd1);
      rdReq = v.rd; wrReq = v.wr;
      rdSel0 = v.s0; rdSel1 = v.s1; wrSel = v.ws; wrData = v.wd;
      @(posedge clk); #1;
      rdReq = 1'b0; wrReq = 1'b0;
      rdSel0 = ~v.s0; rdSel1 = ~v.s1; wrSel = ~v.ws; wrData = ~v.wd;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (rdy == 0 && reqReady) rdy = k;
         if (rdValid) begin
            vcnt++;
            if (vld == 0) begin vld = k; d0 = rdData0; d1 = rdData1; end
         end
         if (!bankCSBar) begin
            if (!bankRDWRBar) begin wcnt++; dsel = bankSelDst; ddat = bankDst; end
            else begin rcnt++; rs0 = bankSelSrc0; rs1 = bankSelSrc1; end
         end
      end
      chk("ready_cycle", 32'(rdy), 32'(v.rdyCyc));
      chk("write_cycles", 32'(wcnt), 32'(v.wrCyc));
      chk("valid_cycle", 32'(vld), 32'(v.vldCyc));
      chk("valid_count", 32'(vcnt), v.rd ? 32'd1 : 32'd0);
      chk("read_cycles", 32'(rcnt), v.rd ? 32'd2 : 32'd0);
      if (wcnt > 0) begin
         chk("wr_sel", 32'(dsel), 32'(v.ws));
         chk("wr_data", ddat, v.wd);
      end
      if (v.rd) begin
         chk("rd_sel0", 32'(rs0), 32'(v.s0));
         chk("rd_sel1", 32'(rs1), 32'(v.s1));
         chk("rdData0", d0, v.e0);
         chk("rdData1", d1, v.e1);
         lastD0 = v.e0; lastD1 = v.e1;
      end else begin
         chk("rdData0_hold", rdData0, lastD0);
         chk("rdData1_hold", rdData1, lastD1);
      end
   endtask

   initial begin
      //            rd    wr    s0     s1     ws     wd            rdy wr vld e0            e1
      vecs[0] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd3,  32'hDEADBEEF, 2, 1, 0, 32'h0,        32'h0};
      vecs[1] = '{1'b1, 1'b0, 5'd5,  5'd6,  5'd0,  32'h0,        3, 0, 3, 32'h11,       32'h22};
      vecs[2] = '{1'b1, 1'b1, 5'd7,  5'd7,  5'd7,  32'hA5A5A5A5, 4, 1, 4, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[3] = '{1'b1, 1'b0, 5'd3,  5'd7,  5'd0,  32'h0,        3, 0, 3, 32'hDEADBEEF, 32'hA5A5A5A5};
`ifdef REGBANK_X0_ZERO_EN
      vecs[4] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 1, 0, 0, 32'h0,        32'h0};
      vecs[5] = '{1'b1, 1'b0, 5'd0,  5'd3,  5'd0,  32'h0,        3, 0, 3, 32'h0,        32'hDEADBEEF};
      vecs[6] = '{1'b1, 1'b1, 5'd0,  5'd5,  5'd0,  32'h12345678, 3, 0, 3, 32'h0,        32'h11};
`else
      vecs[4] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 2, 1, 0, 32'h0,        32'h0};
      vecs[5] = '{1'b1, 1'b0, 5'd0,  5'd3,  5'd0,  32'h0,        3, 0, 3, 32'hFFFFFFFF, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 1'b1, 5'd0,  5'd5,  5'd0,  32'h12345678, 4, 1, 4, 32'h12345678, 32'h11};
`endif
      vecs[7] = '{1'b1, 1'b0, 5'd31, 5'd1,  5'd0,  32'h0,        3, 0, 3, 32'hA000001F, 32'hA0000001};
      vecs[8] = '{1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 32'h0,        4, 1, 4, 32'h0,        32'h0};

      rstBar = 1'b0; rdReq = 1'b0; wrReq = 1'b0;
      rdSel0 = '0; rdSel1 = '0; wrSel = '0; wrData = '0;
      repeat (2) @(negedge clk);
      chk("rst_csbar", 32'(bankCSBar), 32'd1);
      chk("rst_rdwrbar", 32'(bankRDWRBar), 32'd1);
      chk("rst_sels", {17'h0, bankSelSrc0, bankSelSrc1, bankSelDst}, 32'h0);
      chk("rst_dst", bankDst, 32'h0);
      chk("rst_rddata", rdData0 | rdData1, 32'h0);
      chk("rst_valid", 32'(rdValid), 32'd0);
      rstBar = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(reqReady), 32'd1);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Back-to-back: second read issued during the first read's rdValid cycle.
      begin
         int k1 = 0, k2 = 0;
         rdReq = 1'b1; rdSel0 = 5'd5; rdSel1 = 5'd6;
         @(posedge clk); #1 rdReq = 1'b0;
         for (int k = 1; k <= 8 && k1 == 0; k++) begin
            @(negedge clk);
            if (rdValid) k1 = k;
         end
         chk("b2b_first_valid", 32'(k1), 32'd3);
         chk("b2b_ready_in_valid", 32'(reqReady), 32'd1);
         rdReq = 1'b1; rdSel0 = 5'd6; rdSel1 = 5'd5;
         @(posedge clk); #1 rdReq = 1'b0;
         for (int k = 1; k <= 8 && k2 == 0; k++) begin
            @(negedge clk);
            if (rdValid) k2 = k;
         end
         chk("b2b_second_valid", 32'(k2), 32'd3);
         chk("b2b_rdData0", rdData0, 32'h22);
         chk("b2b_rdData1", rdData1, 32'h11);
         @(negedge clk);
      end

      // Reset asserted while the bank read cycle is in progress.
      begin
         int act = 0;
         rdReq = 1'b1; rdSel0 = 5'd5; rdSel1 = 5'd6;
         @(posedge clk); #1 rdReq = 1'b0;
         @(negedge clk);
         chk("midrst_in_read", 32'(bankCSBar), 32'd0);
         rstBar = 1'b0;
         #1;
         chk("midrst_csbar", 32'(bankCSBar), 32'd1);
         chk("midrst_valid", 32'(rdValid), 32'd0);
         chk("midrst_rddata", rdData0 | rdData1, 32'h0);
         repeat (2) @(negedge clk);
         rstBar = 1'b1;
         @(negedge clk);
         chk("midrst_ready", 32'(reqReady), 32'd1);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rdValid || !bankCSBar) act++;
         end
         chk("midrst_no_activity", 32'(act), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
